// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential matrix multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;
    localparam int ACC_W     = 2 * WIDTH_DEF;

    // Saturation selector for acc - prod, width independent: only the sign bits matter.
    // Bit 1 = clamp to max positive, bit 0 = clamp to max negative, 00 = keep result.
    function automatic logic [1:0] sat_sub_sel(input logic acc_neg,
                                               input logic prod_neg,
                                               input logic diff_neg);
        return {~acc_neg & prod_neg & diff_neg, acc_neg & ~prod_neg & ~diff_neg};
    endfunction

endpackage

// File: rtl/matrix_multiply_if.sv
// Operand/result bus between the buffers and the multiplier (START/DONE handshake).
// Latency: n/a (wiring only).
// Backpressure: none; START is only honoured while the multiplier is not busy.
interface matrix_multiply_if #(
    parameter int N     = 3,
    parameter int Din   = 3,
    parameter int Dout  = 3,
    parameter int WIDTH = 8
);
    logic                        START;
    logic signed [WIDTH-1:0]     a [N][Din];
    logic signed [WIDTH-1:0]     b [Din][Dout];
    logic signed [2*WIDTH-1:0]   c [N][Dout];
    logic                        DONE;

    modport master (output START, output a, output b, input c, input DONE);
    modport slave  (input START, input a, input b, output c, output DONE);
endinterface

// File: rtl/matmul_mac.sv
// Combinational signed multiply-subtract: acc_out = acc_in - a*b (MATMUL_SAT_EN selects saturation).
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    input  logic signed [2*WIDTH-1:0] acc_in,
    output logic signed [2*WIDTH-1:0] acc_out
);
    localparam int AW = 2 * WIDTH;

    logic signed [AW-1:0] prod;
    logic signed [AW-1:0] diff;

    // Full-width signed product never overflows 2*WIDTH bits.
    assign prod = AW'(a) * AW'(b);
    assign diff = acc_in - prod;

`ifdef MATMUL_SAT_EN
    logic [1:0] sel;
    assign sel = sat_sub_sel(acc_in[AW-1], prod[AW-1], diff[AW-1]);

    // Clamp to the representable range when the subtract overflows.
    always_comb begin
        acc_out = diff;
        case (sel)
            2'b10:   acc_out = {1'b0, {(AW-1){1'b1}}};
            2'b01:   acc_out = {1'b1, {(AW-1){1'b0}}};
            default: acc_out = diff;
        endcase
    end
`else
    // Plain two's complement wrap-around.
    assign acc_out = diff;
`endif

endmodule

// File: rtl/matrix_multiply.sv
// Sequential C = -(A x B), one MAC per clock; optional saturation via MATMUL_SAT_EN.
// Latency: DONE rises after N*Dout*Din cycles from the accepting START edge.
// Backpressure: START ignored while in CALC; DONE and c hold until the next accepted START.
module matrix_multiply
    import matmul_pkg::*;
#(
    parameter int N     = 3,
    parameter int Din   = 3,
    parameter int Dout  = 3,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    matrix_multiply_if.slave bus
);
    localparam int AW = 2 * WIDTH;
    localparam int IW = (N    > 1) ? $clog2(N)    : 1;
    localparam int JW = (Dout > 1) ? $clog2(Dout) : 1;
    localparam int KW = (Din  > 1) ? $clog2(Din)  : 1;

    state_t state_q, state_d;

    logic [IW-1:0] i_q;
    logic [JW-1:0] j_q;
    logic [KW-1:0] k_q;

    logic signed [WIDTH-1:0] a_q [N][Din];
    logic signed [WIDTH-1:0] b_q [Din][Dout];
    logic signed [AW-1:0]    c_q [N][Dout];
    logic signed [AW-1:0]    acc_q;
    logic signed [AW-1:0]    acc_next;

    logic last_i, last_j, last_k, accept;

    assign last_i = (i_q == IW'(N - 1));
    assign last_j = (j_q == JW'(Dout - 1));
    assign last_k = (k_q == KW'(Din - 1));
    assign accept = bus.START && (state_q != CALC);

    matmul_mac #(.WIDTH(WIDTH)) u_mac (
        .a       (a_q[i_q][k_q]),
        .b       (b_q[k_q][j_q]),
        .acc_in  (acc_q),
        .acc_out (acc_next)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: START accepted from IDLE or DONE, CALC ends after the final MAC.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.START) state_d = CALC;
            CALC:    if (last_i && last_j && last_k) state_d = DONE;
            DONE:    if (bus.START) state_d = CALC;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, index walk (i outer, j middle, k fastest) and result write-back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
            for (int r = 0; r < N; r++)
                for (int q = 0; q < Din; q++) a_q[r][q] <= '0;
            for (int r = 0; r < Din; r++)
                for (int q = 0; q < Dout; q++) b_q[r][q] <= '0;
            for (int r = 0; r < N; r++)
                for (int q = 0; q < Dout; q++) c_q[r][q] <= '0;
        end else if (accept) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
        end else if (state_q == CALC) begin
            if (last_k) begin
                c_q[i_q][j_q] <= acc_next;
                acc_q         <= '0;
                k_q           <= '0;
                if (last_j) begin
                    j_q <= '0;
                    i_q <= last_i ? '0 : i_q + 1'b1;
                end else begin
                    j_q <= j_q + 1'b1;
                end
            end else begin
                acc_q <= acc_next;
                k_q   <= k_q + 1'b1;
            end
        end
    end

    assign bus.c    = c_q;
    assign bus.DONE = (state_q == DONE);

endmodule

// File: tb/tb_matrix_multiply.sv
// Directed self-checking bench for matrix_multiply (3x3x3, 8-bit).
// Latency: checks 27-cycle START-to-DONE timing.
// Backpressure: checks START ignored in CALC and DONE/c hold behaviour.
module tb_matrix_multiply;

    typedef logic signed [7:0]  mat_t [3][3];
    typedef logic signed [15:0] res_t [3][3];

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    matrix_multiply_if #(.N(3), .Din(3), .Dout(3), .WIDTH(8)) bus ();

    matrix_multiply #(.N(3), .Din(3), .Dout(3), .WIDTH(8)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mat_t m_a;
    mat_t m_id;
    mat_t m_b;
    mat_t m_neg;
    mat_t m_zero;
    res_t r_a;
    res_t r_id;
    res_t r_neg;
    res_t r_zero;

    // Called at a negedge; the accepting edge is the following posedge.
    task automatic pulse_start(input mat_t ma, input mat_t mb);
        bus.a     = ma;
        bus.b     = mb;
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (bus.DONE !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        bus.START = 1'b0;
        bus.a     = m_zero;
        bus.b     = m_zero;
        #1;
        checks++;
        if (bus.DONE !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got %0b expected 0", bus.DONE);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (bus.c[i][j] !== 16'sd0) begin
                    errors++;
                    $display("FAIL reset_c[%0d][%0d] got %0d expected 0", i, j, bus.c[i][j]);
                end
            end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int cyc;
        pulse_start(m_a, m_a);
        wait_done(60, cyc);
        checks++;
        if (cyc !== 27) begin
            errors++;
            $display("FAIL basic_latency got %0d expected 27", cyc);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (bus.c[i][j] !== r_a[i][j]) begin
                    errors++;
                    $display("FAIL basic_c[%0d][%0d] got %0d expected %0d", i, j, bus.c[i][j], r_a[i][j]);
                end
            end
    endtask

    // Identity x B, operands scrambled after capture, then DONE/c must hold.
    task automatic test_hold;
        int cyc;
        pulse_start(m_id, m_b);
        bus.a = m_zero;
        bus.b = m_zero;
        wait_done(60, cyc);
        checks++;
        if (cyc !== 27) begin
            errors++;
            $display("FAIL hold_latency got %0d expected 27", cyc);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (bus.DONE !== 1'b1) begin
            errors++;
            $display("FAIL hold_done got %0b expected 1", bus.DONE);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (bus.c[i][j] !== r_id[i][j]) begin
                    errors++;
                    $display("FAIL hold_c[%0d][%0d] got %0d expected %0d", i, j, bus.c[i][j], r_id[i][j]);
                end
            end
    endtask

    task automatic test_back_to_back;
        int cyc;
        pulse_start(m_a, m_a);
        checks++;
        if (bus.DONE !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_drop got %0b expected 0", bus.DONE);
        end
        checks++;
        if (bus.c[2][2] !== -16'sd9) begin
            errors++;
            $display("FAIL b2b_old_c22 got %0d expected -9", bus.c[2][2]);
        end
        wait_done(60, cyc);
        checks++;
        if (cyc !== 27) begin
            errors++;
            $display("FAIL b2b_latency got %0d expected 27", cyc);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (bus.c[i][j] !== r_a[i][j]) begin
                    errors++;
                    $display("FAIL b2b_c[%0d][%0d] got %0d expected %0d", i, j, bus.c[i][j], r_a[i][j]);
                end
            end
    endtask

    task automatic test_wrap;
        int cyc;
        pulse_start(m_neg, m_neg);
        wait_done(60, cyc);
        checks++;
        if (cyc !== 27) begin
            errors++;
            $display("FAIL wrap_latency got %0d expected 27", cyc);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (bus.c[i][j] !== r_neg[i][j]) begin
                    errors++;
                    $display("FAIL wrap_c[%0d][%0d] got %0d expected %0d", i, j, bus.c[i][j], r_neg[i][j]);
                end
            end
    endtask

    task automatic test_ignore_start;
        int cyc;
        pulse_start(m_a, m_a);
        repeat (5) @(negedge clk);
        pulse_start(m_id, m_b);
        wait_done(60, cyc);
        checks++;
        if (cyc !== 21) begin
            errors++;
            $display("FAIL ignore_latency got %0d expected 21", cyc);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (bus.c[i][j] !== r_a[i][j]) begin
                    errors++;
                    $display("FAIL ignore_c[%0d][%0d] got %0d expected %0d", i, j, bus.c[i][j], r_a[i][j]);
                end
            end
    endtask

    task automatic test_reset_mid;
        int cyc;
        pulse_start(m_id, m_b);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.DONE !== 1'b0) begin
            errors++;
            $display("FAIL midrst_done got %0b expected 0", bus.DONE);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (bus.c[i][j] !== r_zero[i][j]) begin
                    errors++;
                    $display("FAIL midrst_c[%0d][%0d] got %0d expected 0", i, j, bus.c[i][j]);
                end
            end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start(m_a, m_a);
        wait_done(60, cyc);
        checks++;
        if (cyc !== 27) begin
            errors++;
            $display("FAIL midrst_latency got %0d expected 27", cyc);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (bus.c[i][j] !== r_a[i][j]) begin
                    errors++;
                    $display("FAIL midrst_c_after[%0d][%0d] got %0d expected %0d", i, j, bus.c[i][j], r_a[i][j]);
                end
            end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;

        m_a    = '{'{-8'sd1, 8'sd2, -8'sd3}, '{8'sd4, -8'sd5, 8'sd6}, '{-8'sd7, 8'sd8, -8'sd9}};
        m_id   = '{'{8'sd1, 8'sd0, 8'sd0}, '{8'sd0, 8'sd1, 8'sd0}, '{8'sd0, 8'sd0, 8'sd1}};
        m_b    = '{'{8'sd1, 8'sd2, 8'sd3}, '{8'sd4, 8'sd5, 8'sd6}, '{8'sd7, 8'sd8, 8'sd9}};
        r_a    = '{'{-16'sd30, 16'sd36, -16'sd42}, '{16'sd66, -16'sd81, 16'sd96},
                   '{-16'sd102, 16'sd126, -16'sd150}};
        r_id   = '{'{-16'sd1, -16'sd2, -16'sd3}, '{-16'sd4, -16'sd5, -16'sd6},
                   '{-16'sd7, -16'sd8, -16'sd9}};
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                m_neg[i][j]  = -8'sd128;
                m_zero[i][j] = 8'sd0;
                r_zero[i][j] = 16'sd0;
`ifdef MATMUL_SAT_EN
                r_neg[i][j]  = -16'sd32768;
`else
                r_neg[i][j]  = 16'sd16384;
`endif
            end

        @(negedge clk);
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_wrap();
        test_ignore_start();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
